link_tx_scheduler: RTL and testbench
====================================

// Module: link_tx_scheduler
// PURPOSE
//  Shares the single byte-wide link transmitter (start/finish handshake, 8-bit parallel data,
//  far-end strobe/ack) between N_REQ local requesters. Round-robin arbitration, one byte per
//  grant. Sequences the transmitter's start pulse, tracks its busy/finish cycle, returns a
//  per-requester completion pulse, and flags a stalled link with a sticky watchdog error.
// PARAMETERS
//  N_REQ      4     number of requesters (2..8)
//  ID_W       2     width of grant_id, = clog2(N_REQ)
//  TIMEOUT    1023  cycles in WAIT_BUSY+WAIT_DONE before timeout_err sets
//  TMO_W      10    watchdog counter width, must hold TIMEOUT
// PORTS
//  clk          in   1          system clock, all logic on posedge
//  rst_n        in   1          asynchronous, active-low reset
//  req          in   N_REQ      per-requester request, level; hold until own ack
//  req_data     in   N_REQ*8    byte of requester i at [8i+7:8i]; stable while req[i]=1
//  ack          out  N_REQ      one-cycle pulse: requester's byte fully sent and acknowledged
//  tx_start     out  1          start strobe to transmitter, exactly one cycle per grant
//  tx_data      out  8          byte to transmitter, held from grant until DONE
//  tx_finish    in   1          transmitter idle/finish flag (1 = idle, registered in transmitter)
//  busy         out  1          1 from grant until ack pulse, inclusive
//  grant_id     out  ID_W       index of current/last granted requester
//  timeout_err  out  1          sticky: link stalled >= TIMEOUT cycles in one transfer
//  clear_err    in   1          synchronous clear of timeout_err
// BEHAVIOUR
//  Reset: state=IDLE, tx_start=0, tx_data=0, ack=0, busy=0, grant_id=0, timeout_err=0,
//   rr pointer=N_REQ-1 (req[0] has first priority). All outputs registered.
//  FSM:
//   IDLE      : if tx_finish=1 and |req: pick winner, latch grant_id + its byte into tx_data,
//               busy<=1, -> START. Else stay. No grant while tx_finish=0.
//   START     : tx_start=1 this cycle only -> WAIT_BUSY.
//   WAIT_BUSY : wait tx_finish=0 (transmitter accepted) -> WAIT_DONE.
//   WAIT_DONE : wait tx_finish=1 (far end acked, transmitter back to idle) -> DONE.
//   DONE      : ack[grant_id]=1 one cycle, busy<=0, rr pointer<=grant_id -> IDLE.
//  Latency: req sampled in IDLE -> tx_start high 1 cycle after grant edge; min req-to-ack
//   is grant + 1 (START) + transmitter cycle + 1 (DONE); next grant no earlier than cycle after DONE.
//  Arbitration: search starts at pointer+1, wraps modulo N_REQ; first set req wins.
//   Winner just served has lowest priority next round. Single requester may win back-to-back.
//  req handling: req dropped before grant = withdrawn, no ack. After grant, req/req_data of
//   all requesters ignored until DONE; tx_data never changes mid-transfer.
//  Watchdog: counter clears on entering WAIT_BUSY, increments each cycle in WAIT_BUSY/WAIT_DONE,
//   saturates at TIMEOUT; reaching TIMEOUT sets timeout_err. FSM keeps waiting (link has no abort).
//   clear_err and set in same cycle: set wins. clear_err outside stall clears next edge.
//  Reset mid-transfer: outputs return to reset values immediately (async). Transmitter is not
//   reset by this block; IDLE's tx_finish=1 condition prevents a new start until it drains.
//  ack is one-hot or zero; never asserted outside DONE.
// STRUCTURE
//  Shared package link_pkg: LINK_BYTE_W=8, FSM state typedef/encoding
//   (IDLE, START, WAIT_BUSY, WAIT_DONE, DONE), default TIMEOUT.
//  Sub-module rr_arbiter (combinational): inputs req, pointer; outputs winner id + valid.
//   FSM, data latch, watchdog stay in link_tx_scheduler.
// TESTING (bench includes behavioural transmitter model: finish drops 1 cycle after start,
//  far-end ack after programmable delay D)
//  1 Reset, single req[2]=1 data 8'hA5, D=3 -> one tx_start pulse, tx_data=A5, grant_id=2,
//    ack=4'b0100 single pulse, busy low after ack.
//  2 req=4'b1111 held, bytes 11/22/33/44, D=0 -> grants in order 0,1,2,3,0; no gap larger than
//    one IDLE cycle between ack and next tx_start.
//  3 req[1] asserted while transfer for req[3] active -> req[1] granted next, tx_data unchanged
//    (=req[3] byte) until ack[3].
//  4 D=TIMEOUT+5 -> timeout_err rises at cycle TIMEOUT of stall, transfer still completes with ack;
//    clear_err pulse afterwards -> timeout_err=0; clear_err on set cycle -> stays 1.
//  5 rst_n low during WAIT_DONE, release while model still busy -> no tx_start until tx_finish=1,
//    then req[0] granted first.
//  6 req[2] pulsed 1 cycle while tx_finish=0 then dropped -> no grant, no ack, busy stays 0.

Source files
------------

// File: rtl/link_pkg.sv
// -----------------------------------------------------------------------------
// link_pkg
// Shared definitions for the byte-wide link transmit path: the link byte width,
// the default stall watchdog limit and the scheduler FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package link_pkg;

  localparam int LINK_BYTE_W     = 8;
  localparam int DEFAULT_TIMEOUT = 1023;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } link_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts one slot past 'pointer'
// and wraps modulo N_REQ, so the requester named by 'pointer' (the one served
// last) has the lowest priority.
// Ports:
//   req     in   N_REQ  request vector
//   pointer in   ID_W   index of the requester served last
//   winner  out  ID_W   index of the chosen requester (0 when none)
//   valid   out  1      at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter
  import link_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  pointer,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);

  function automatic logic [ID_W-1:0] slot(input logic [ID_W-1:0] ptr, input int offset);
    return ID_W'((int'(ptr) + offset) % N_REQ);
  endfunction

  // Walk from the lowest priority slot towards the highest; the last hit
  // overwrites earlier ones, leaving the highest priority request as winner.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[slot(pointer, i)]) begin
        valid  = 1'b1;
        winner = slot(pointer, i);
      end
    end
  end

endmodule

// File: rtl/link_tx_scheduler.sv
// -----------------------------------------------------------------------------
// link_tx_scheduler
// Shares one byte-wide link transmitter between N_REQ requesters, one byte per
// grant in round-robin order. Issues a single-cycle start strobe, follows the
// transmitter's finish flag through its busy/idle cycle, pulses the winner's
// ack when the far end has acknowledged, and raises a sticky timeout error when
// a transfer stalls for TIMEOUT cycles.
// Ports:
//   clk          in   1        system clock
//   rst_n        in   1        asynchronous active-low reset
//   req          in   N_REQ    per-requester request level
//   req_data     in   N_REQ*8  requester i byte at [8i+7:8i]
//   ack          out  N_REQ    one-cycle completion pulse, one-hot or zero
//   tx_start     out  1        start strobe to the transmitter
//   tx_data      out  8        byte to the transmitter, held for the transfer
//   tx_finish    in   1        transmitter idle/finish flag (1 = idle)
//   busy         out  1        transfer in progress, grant through ack
//   grant_id     out  ID_W     current/last granted requester
//   timeout_err  out  1        sticky stall error
//   clear_err    in   1        synchronous clear of timeout_err
// -----------------------------------------------------------------------------
module link_tx_scheduler
  import link_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TMO_W   = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*LINK_BYTE_W-1:0] req_data,
  output logic [N_REQ-1:0]             ack,
  output logic                         tx_start,
  output logic [LINK_BYTE_W-1:0]       tx_data,
  input  logic                         tx_finish,
  output logic                         busy,
  output logic [ID_W-1:0]              grant_id,
  output logic                         timeout_err,
  input  logic                         clear_err
);

  link_state_t      state, next_state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  win_id;
  logic             win_valid;
  logic             grant;
  logic             stalled;
  logic             wd_hit;
  logic [TMO_W-1:0] wd_cnt;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req     (req),
    .pointer (rr_ptr),
    .winner  (win_id),
    .valid   (win_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A grant needs an idle transmitter as well as a request: after a reset in
  // mid-transfer the transmitter may still be draining the old byte.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (tx_finish && win_valid) next_state = START;
      START:     next_state = WAIT_BUSY;
      WAIT_BUSY: if (!tx_finish) next_state = WAIT_DONE;
      WAIT_DONE: if (tx_finish) next_state = DONE;
      DONE:      next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  assign grant   = (state == IDLE) && (next_state == START);
  assign stalled = (state == WAIT_BUSY) || (state == WAIT_DONE);
  // The edge that brings the count to TIMEOUT also sets the error; while the
  // count sits saturated the set keeps winning over clear_err.
  assign wd_hit  = stalled && (wd_cnt >= TMO_W'(TIMEOUT - 1));

  // All outputs are registered from the next-state decision so each one
  // changes on the same edge as the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start    <= 1'b0;
      tx_data     <= '0;
      ack         <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= ID_W'(N_REQ - 1);
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      tx_start <= grant;
      busy     <= (next_state != IDLE);
      ack      <= (next_state == DONE) ? (N_REQ'(1) << grant_id) : '0;

      if (grant) begin
        grant_id <= win_id;
        tx_data  <= req_data[win_id*LINK_BYTE_W +: LINK_BYTE_W];
      end

      if (state == DONE) rr_ptr <= grant_id;

      if (state == START)
        wd_cnt <= '0;
      else if (stalled && (wd_cnt != TMO_W'(TIMEOUT)))
        wd_cnt <= wd_cnt + 1'b1;

      if (wd_hit)         timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_link_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_link_tx_scheduler
// Bench for link_tx_scheduler: a behavioural transmitter (finish drops one
// cycle after start, returns after a programmable far-end delay), a
// transaction-level model of the scheduler compared on every cycle, directed
// scenarios with literal expectations, then a randomized requester phase.
// -----------------------------------------------------------------------------
module tb_link_tx_scheduler;

  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 40;
  localparam int TMO_W   = 6;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic [3:0]  req       = '0;
  logic [31:0] req_data  = '0;
  logic        clear_err = 1'b0;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_finish;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  link_tx_scheduler #(
    .N_REQ   (N_REQ),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_finish   (tx_finish),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .clear_err   (clear_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter: accepts a start while idle, drops finish on the next cycle,
  // stays busy for d_delay+1 cycles, then returns to idle. It is never reset
  // by the scheduler's reset. force_low holds finish low from outside.
  logic xmt_idle  = 1'b1;
  int   xmt_cnt   = 0;
  int   d_delay   = 0;
  logic force_low = 1'b0;

  assign tx_finish = xmt_idle & ~force_low;

  always @(posedge clk) begin
    if (!xmt_idle) begin
      if (xmt_cnt == 0) xmt_idle <= 1'b1;
      else              xmt_cnt  <= xmt_cnt - 1;
    end else if (tx_start === 1'b1) begin
      xmt_idle <= 1'b0;
      xmt_cnt  <= d_delay;
    end
  end

  // Reference model: one transfer at a time. A transfer is granted when the
  // link is idle and someone asks; the start cycle follows; then the model
  // waits to see finish fall and rise again, acks on the cycle after that and
  // passes priority past the served requester.
  logic       m_start, m_busy, m_err, m_granted, m_low_seen;
  logic [7:0] m_data;
  logic [3:0] m_ack;
  logic [1:0] m_id, m_ptr;
  int         m_wait;
  int         m_win;

  function automatic int pickWinner(input logic [3:0] r, input logic [1:0] p);
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = 2'(int'(p) + k);
      if (r[idx]) return int'(idx);
    end
    return -1;
  endfunction

  always_comb m_win = pickWinner(req, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_start    <= 1'b0;
      m_busy     <= 1'b0;
      m_err      <= 1'b0;
      m_granted  <= 1'b0;
      m_low_seen <= 1'b0;
      m_data     <= '0;
      m_ack      <= '0;
      m_id       <= '0;
      m_ptr      <= 2'd3;
      m_wait     <= 0;
    end else begin
      m_start <= 1'b0;
      m_ack   <= '0;
      if (m_ack != 0) begin
        m_busy    <= 1'b0;
        m_ptr     <= m_id;
        m_granted <= 1'b0;
      end else if (!m_granted) begin
        if (tx_finish && m_win >= 0) begin
          m_granted <= 1'b1;
          m_busy    <= 1'b1;
          m_start   <= 1'b1;
          m_id      <= 2'(m_win);
          m_data    <= req_data[8*m_win +: 8];
        end
      end else if (m_start) begin
        m_wait     <= 0;
        m_low_seen <= 1'b0;
      end else begin
        if (m_wait < TIMEOUT) m_wait <= m_wait + 1;
        if (!m_low_seen) begin
          if (!tx_finish) m_low_seen <= 1'b1;
        end else if (tx_finish) begin
          m_ack <= 4'b0001 << m_id;
        end
      end
      if (m_granted && !m_start && m_ack == 0 && m_wait >= TIMEOUT - 1) m_err <= 1'b1;
      else if (clear_err) m_err <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge clk) begin
    checkOutput("tx_start",    32'(tx_start),    32'(m_start));
    checkOutput("tx_data",     32'(tx_data),     32'(m_data));
    checkOutput("ack",         32'(ack),         32'(m_ack));
    checkOutput("busy",        32'(busy),        32'(m_busy));
    checkOutput("grant_id",    32'(grant_id),    32'(m_id));
    checkOutput("timeout_err", 32'(timeout_err), 32'(m_err));
  end

  task automatic applyStimulus(input logic [3:0] r);
    @(negedge clk);
    req = r;
  endtask

  task automatic waitStart(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_start got none expected tx_start within %0d cycles", limit);
    end
  endtask

  task automatic waitAck(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ack !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_ack got none expected ack within %0d cycles", limit);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout got still running expected finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int         t0, last_ack, fin_cyc;
    logic [1:0] exp_ids [5];
    logic [7:0] exp_bytes [5];
    exp_ids   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    // Scenario 1: reset values, then a single byte from requester 2.
    repeat (2) @(negedge clk);
    checkOutput("rst_busy",     32'(busy),     32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst_tx_data",  32'(tx_data),  32'd0);
    #1 rst_n = 1'b1;
    d_delay = 3;
    req_data[23:16] = 8'hA5;
    applyStimulus(4'b0100);
    waitStart(20);
    t0 = cyc;
    checkOutput("t1_grant_id", 32'(grant_id), 32'd2);
    checkOutput("t1_tx_data",  32'(tx_data),  32'hA5);
    waitAck(50);
    checkOutput("t1_ack",     32'(ack),    32'h4);
    checkOutput("t1_latency", 32'(cyc - t0), 32'd6);
    req = 4'b0000;
    @(negedge clk);
    checkOutput("t1_busy_after", 32'(busy), 32'd0);
    checkOutput("t1_ack_after",  32'(ack),  32'd0);

    // Scenario 2: all four requesting from reset, D=0.
    resetDut();
    d_delay  = 0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req      = 4'b1111;
    last_ack = 0;
    for (int i = 0; i < 5; i++) begin
      waitStart(20);
      checkOutput("t2_grant_id", 32'(grant_id), 32'(exp_ids[i]));
      checkOutput("t2_tx_data",  32'(tx_data),  32'(exp_bytes[i]));
      if (i > 0) checkOutput("t2_ack_to_start", 32'(cyc - last_ack), 32'd2);
      if (i == 4) req = 4'b0000;
      waitAck(20);
      last_ack = cyc;
    end

    // Scenario 3: requester 1 arrives while requester 3 is being served.
    d_delay = 4;
    req_data[31:24] = 8'h9C;
    req_data[15:8]  = 8'h77;
    applyStimulus(4'b1000);
    waitStart(20);
    checkOutput("t3_first_grant", 32'(grant_id), 32'd3);
    req = 4'b1010;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack != 4'b0000) break;
      checkOutput("t3_data_hold", 32'(tx_data), 32'h9C);
    end
    checkOutput("t3_ack", 32'(ack), 32'h8);
    req = 4'b0010;
    waitStart(20);
    checkOutput("t3_second_grant", 32'(grant_id), 32'd1);
    checkOutput("t3_second_data",  32'(tx_data),  32'h77);
    waitAck(40);
    req = 4'b0000;

    // Scenario 4: stalled transfer trips the watchdog; clear on the set cycle
    // loses, clear afterwards wins.
    d_delay = TIMEOUT + 5;
    req_data[7:0] = 8'h5A;
    applyStimulus(4'b0001);
    waitStart(20);
    repeat (TIMEOUT) @(negedge clk);
    checkOutput("t4_err_before", 32'(timeout_err), 32'd0);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checkOutput("t4_err_set", 32'(timeout_err), 32'd1);
    waitAck(100);
    checkOutput("t4_ack", 32'(ack), 32'h1);
    req = 4'b0000;
    @(negedge clk);
    checkOutput("t4_err_sticky", 32'(timeout_err), 32'd1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checkOutput("t4_err_cleared", 32'(timeout_err), 32'd0);

    // Scenario 5: reset while the transmitter is mid-byte.
    d_delay = 20;
    req_data[23:16] = 8'h3E;
    req_data[7:0]   = 8'hC3;
    applyStimulus(4'b0100);
    waitStart(20);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    req = 4'b0101;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    fin_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_start === 1'b1) break;
      if (tx_finish && fin_cyc < 0) fin_cyc = cyc;
    end
    checkOutput("t5_grant_after_reset", 32'(grant_id), 32'd0);
    checkOutput("t5_start_after_drain", 32'(cyc - fin_cyc), 32'd1);
    waitAck(60);
    checkOutput("t5_ack", 32'(ack), 32'h1);
    req = 4'b0100;
    waitStart(20);
    checkOutput("t5_next_grant", 32'(grant_id), 32'd2);
    waitAck(60);
    req = 4'b0000;

    // Scenario 6: a request pulse while the transmitter is not idle is lost.
    @(negedge clk);
    force_low = 1'b1;
    applyStimulus(4'b0100);
    applyStimulus(4'b0000);
    @(negedge clk);
    force_low = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checkOutput("t6_busy",     32'(busy),     32'd0);
      checkOutput("t6_ack",      32'(ack),      32'd0);
      checkOutput("t6_tx_start", 32'(tx_start), 32'd0);
    end

    // Randomized requesters: hold until own ack, occasionally withdraw while
    // not being served, random far-end delays with occasional stalls.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end else if (req[i] && !(busy && grant_id == 2'(i)) && $urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end
      end
      d_delay   = ($urandom_range(0, 19) == 0) ? TIMEOUT + 5 : int'($urandom_range(0, 4));
      clear_err = ($urandom_range(0, 15) == 0);
    end
    req       = 4'b0000;
    clear_err = 1'b0;
    repeat (120) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
